// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time against an internal word RAM,
// with byte/halfword/word lanes, sign/zero extension and wait states.
// Ports: clk, rst_n (sync, active-low); request side req_valid/req_ready,
// req_write, req_size, req_signed, address, write_data; response side
// resp_valid (1-cycle pulse), read_data, error; stall = req_valid && !req_ready.
module load_store_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] address,
  input  logic [WIDTH-1:0] write_data,
  output logic             resp_valid,
  output logic [WIDTH-1:0] read_data,
  output logic             error,
  output logic             stall
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(4 * DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             accept;
  logic             misal;
  logic             bad;

  logic             a_write;
  logic [1:0]       a_size;
  logic             a_signed;
  logic [AW+1:0]    a_addr;
  logic [WIDTH-1:0] a_wdata;
  logic             a_err;
  logic [AW-1:0]    a_idx;

  logic [3:0]       a_be;
  logic [WIDTH-1:0] a_wlane;
  logic [WIDTH-1:0] word;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [WIDTH-1:0] load_val;

  assign req_ready = (state == IDLE);
  assign stall     = req_valid && !req_ready;
  assign accept    = req_valid && req_ready;
  assign a_idx     = a_addr[AW+1:2];

  always_comb begin
    misal = 1'b0;
    unique case (req_size)
      2'b00:   misal = 1'b0;
      2'b01:   misal = address[0];
      2'b10:   misal = |address[1:0];
      default: misal = 1'b1;
    endcase
    bad = misal || (address >= LIMIT);
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bad || WAIT == 0) begin
            state_next = RESP;
          end else begin
            state_next = BUSY;
            cnt_next   = 4'(WAIT - 1);
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The response is registered out of RESP, so the RAM write and the
  // resp_valid pulse land on the same edge and a reset there cancels both.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      error      <= 1'b0;
      read_data  <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      resp_valid <= (state == RESP);
      error      <= (state == RESP) && a_err;
      if (state == RESP) begin
        read_data <= (a_err || a_write) ? '0 : load_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      a_write  <= req_write;
      a_size   <= req_size;
      a_signed <= req_signed;
      a_addr   <= address[AW+1:0];
      a_wdata  <= write_data;
      a_err    <= bad;
    end
  end

  always_comb begin
    a_be    = 4'b0000;
    a_wlane = a_wdata;
    unique case (a_size)
      2'b00: begin
        a_be    = 4'b0001 << a_addr[1:0];
        a_wlane = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        a_be    = a_addr[1] ? 4'b1100 : 4'b0011;
        a_wlane = {2{a_wdata[15:0]}};
      end
      default: begin
        a_be    = 4'b1111;
        a_wlane = a_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && state == RESP && a_write && !a_err) begin
      for (int i = 0; i < 4; i++) begin
        if (a_be[i]) begin
          mem[a_idx][8*i +: 8] <= a_wlane[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    word   = mem[a_idx];
    byte_v = word[7:0];
    unique case (a_addr[1:0])
      2'b00:   byte_v = word[7:0];
      2'b01:   byte_v = word[15:8];
      2'b10:   byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = a_addr[1] ? word[31:16] : word[15:0];
    unique case (a_size)
      2'b00:   load_val = {{(WIDTH-8){a_signed & byte_v[7]}}, byte_v};
      2'b01:   load_val = {{(WIDTH-16){a_signed & half_v[15]}}, half_v};
      default: load_val = word;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table on a WAIT=2 instance,
// hand sequences for stall, reset abort, and a WAIT=0 instance.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rv0, rv1;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] address;
  logic [31:0] write_data;

  logic        rdy0, stall0, rsp0, er0;
  logic [31:0] rd0;
  logic        rdy1, stall1, rsp1, er1;
  logic [31:0] rd1;

  bit          sel;
  logic        rdy, stl, rsp, er;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32), .DEPTH(256), .WAIT(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(rdy0),
    .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .address(address),
    .write_data(write_data), .resp_valid(rsp0),
    .read_data(rd0), .error(er0), .stall(stall0)
  );

  load_store_unit #(.WIDTH(32), .DEPTH(256), .WAIT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rdy1),
    .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .address(address),
    .write_data(write_data), .resp_valid(rsp1),
    .read_data(rd1), .error(er1), .stall(stall1)
  );

  always_comb begin
    rdy = sel ? rdy1 : rdy0;
    stl = sel ? stall1 : stall0;
    rsp = sel ? rsp1 : rsp0;
    er  = sel ? er1 : er0;
    rd  = sel ? rd1 : rd0;
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string nm, input int id,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, id, got, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel) rv1 = v;
    else rv0 = v;
  endtask

  // Wait for resp_valid after an acceptance edge; n = edges until seen.
  task automatic wait_resp(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (rsp) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run(input vec_t v, input int id);
    int n;
    logic [31:0] held;
    @(negedge clk);
    chk("ready_before", id, 32'(rdy), 32'd1);
    req_write  = v.wr;
    req_size   = v.size;
    req_signed = v.sgn;
    address    = v.addr;
    write_data = v.wdata;
    set_valid(1'b1);
    @(posedge clk); #1;
    set_valid(1'b0);
    req_write  = ~v.wr;
    req_size   = ~v.size;
    req_signed = ~v.sgn;
    address    = ~v.addr;
    write_data = ~v.wdata;
    wait_resp(n);
    chk("latency", id, 32'(n), 32'(v.exp_lat));
    chk("read_data", id, rd, v.exp_data);
    chk("error", id, 32'(er), 32'(v.exp_err));
    held = rd;
    @(posedge clk); #1;
    chk("resp_pulse", id, 32'(rsp), 32'd0);
    chk("error_idle", id, 32'(er), 32'd0);
    chk("read_hold", id, rd, held);
  endtask

  initial begin
    int n;
    sel        = 1'b0;
    rst_n      = 1'b0;
    rv0        = 1'b1;
    rv1        = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b10;
    req_signed = 1'b0;
    address    = 32'h0;
    write_data = 32'h0;

    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0,   32'hCAFEF00D, 32'h0, 1'b0, 3};
    vecs[1]  = '{1'b1, 2'b10, 1'b0, 32'h4,   32'h11223344, 32'h0, 1'b0, 3};
    vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'h4,   32'h0, 32'h11223344, 1'b0, 3};
    vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h6,   32'hFFFFFFAB, 32'h0, 1'b0, 3};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h4,   32'h0, 32'h11AB3344, 1'b0, 3};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h6,   32'h0, 32'hFFFFFFAB, 1'b0, 3};
    vecs[6]  = '{1'b0, 2'b00, 1'b0, 32'h6,   32'h0, 32'h000000AB, 1'b0, 3};
    vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h5,   32'h0, 32'h0, 1'b1, 1};
    vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h400, 32'hDEADBEEF, 32'h0, 1'b1, 1};
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h0,   32'h0, 32'hCAFEF00D, 1'b0, 3};
    vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h2,   32'h12348001, 32'h0, 1'b0, 3};
    vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h0,   32'h0, 32'h8001F00D, 1'b0, 3};
    vecs[12] = '{1'b0, 2'b01, 1'b1, 32'h2,   32'h0, 32'hFFFF8001, 1'b0, 3};
    vecs[13] = '{1'b0, 2'b01, 1'b0, 32'h2,   32'h0, 32'h00008001, 1'b0, 3};
    vecs[14] = '{1'b0, 2'b00, 1'b1, 32'h1,   32'h0, 32'hFFFFFFF0, 1'b0, 3};
    vecs[15] = '{1'b0, 2'b00, 1'b0, 32'h3,   32'h0, 32'h00000080, 1'b0, 3};
    vecs[16] = '{1'b0, 2'b10, 1'b0, 32'h2,   32'h0, 32'h0, 1'b1, 1};
    vecs[17] = '{1'b0, 2'b11, 1'b0, 32'h0,   32'h0, 32'h0, 1'b1, 1};
    vecs[18] = '{1'b1, 2'b01, 1'b0, 32'h6,   32'hABCD5566, 32'h0, 1'b0, 3};
    vecs[19] = '{1'b0, 2'b10, 1'b0, 32'h4,   32'h0, 32'h55663344, 1'b0, 3};

    // Reset with a request pending: nothing may be accepted.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp", 0, 32'(rsp0), 32'd0);
    chk("rst_error", 0, 32'(er0), 32'd0);
    chk("rst_rdata", 0, rd0, 32'd0);
    chk("rst_ready", 0, 32'(rdy0), 32'd1);
    chk("rst_stall", 0, 32'(stall0), 32'd0);
    @(negedge clk);
    rv0   = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run(vecs[i], i);

    // Held request: stalls while busy, second accepted right after resp.
    @(negedge clk);
    req_write  = 1'b0;
    req_size   = 2'b10;
    req_signed = 1'b0;
    address    = 32'h4;
    rv0        = 1'b1;
    @(posedge clk); #1;
    chk("stall_busy", 0, 32'(stall0), 32'd1);
    chk("ready_busy", 0, 32'(rdy0), 32'd0);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (rsp0) begin
        n = i;
        break;
      end
      chk("stall_wait", i, 32'(stall0), 32'd1);
    end
    chk("stall_lat1", 0, 32'(n), 32'd3);
    chk("stall_data1", 0, rd0, 32'h55663344);
    @(posedge clk); #1;
    chk("second_accept", 0, 32'(rdy0), 32'd0);
    rv0 = 1'b0;
    wait_resp(n);
    chk("stall_lat2", 0, 32'(n), 32'd3);
    chk("stall_data2", 0, rd0, 32'h55663344);
    @(posedge clk); #1;

    // Reset one cycle after a store is accepted cancels it.
    run('{1'b1, 2'b10, 1'b0, 32'h8, 32'h01020304, 32'h0, 1'b0, 3}, 30);
    @(negedge clk);
    req_write  = 1'b1;
    req_size   = 2'b10;
    address    = 32'h8;
    write_data = 32'hFFFFFFFF;
    rv0        = 1'b1;
    @(posedge clk); #1;
    rv0   = 1'b0;
    rst_n = 1'b0;
    n = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (rsp0) n++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (rsp0) n++;
    end
    chk("abort_resp", 0, 32'(n), 32'd0);
    run('{1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h01020304, 1'b0, 3}, 31);

    // Zero wait states.
    sel = 1'b1;
    run('{1'b1, 2'b10, 1'b0, 32'h0, 32'h5A5AA5A5, 32'h0, 1'b0, 1}, 40);
    run('{1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h5A5AA5A5, 1'b0, 1}, 41);
    run('{1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 32'h00005A5A, 1'b0, 1}, 42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
- REQ-001: Parameter WIDTH, default 32, data and address width in bits; legal value 32 only.
- REQ-002: Parameter DEPTH, default 256, number of WIDTH-bit words in the internal data RAM; power of two.
- REQ-003: Parameter WAIT, default 2, number of wait-state cycles per access; range 0..15.
- REQ-004: clk  input  1  single clock; all state changes on the rising edge.
- REQ-005: rst_n  input  1  reset; synchronous, active-low.
- REQ-006: req_valid  input  1  request present.
- REQ-007: req_ready  output  1  unit can accept a request this cycle.
- REQ-008: req_write  input  1  1 = store, 0 = load.
- REQ-009: req_size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- REQ-010: req_signed  input  1  load extension: 1 = sign-extend, 0 = zero-extend.
- REQ-011: address  input  WIDTH  byte address.
- REQ-012: write_data  input  WIDTH  store data, right-justified.
- REQ-013: resp_valid  output  1  one-cycle pulse that completes an access.
- REQ-014: read_data  output  WIDTH  load result, extended to WIDTH.
- REQ-015: error  output  1  qualified by resp_valid; the access was misaligned, out of range or reserved size.
- REQ-016: stall  output  1  pipeline hold: req_valid && !req_ready.

Function
- REQ-017: The FSM SHALL have three states: IDLE, BUSY and RESP. req_ready SHALL be 1 only in IDLE.
- REQ-018: A request SHALL be accepted at an edge where req_valid=1 and req_ready=1. On acceptance, all req_* inputs, address and write_data SHALL be latched. Later input changes SHALL have no effect on that access.
- REQ-019: Error conditions at acceptance: halfword with address[0]=1; word with address[1:0]!=0; req_size=11; address >= 4*DEPTH. Any of these SHALL make the FSM go IDLE->RESP directly with error=1, no RAM write, and read_data=0.
- REQ-020: A legal access accepted at edge k:
  - WAIT>0: IDLE->BUSY, a wait counter loads WAIT-1 and decrements each cycle, and BUSY->RESP when the counter is 0.
  - WAIT=0: IDLE->RESP directly.
  - In both cases resp_valid SHALL rise at edge k+WAIT+1.
- REQ-021: An error access accepted at edge k SHALL assert resp_valid at edge k+1, regardless of WAIT.
- REQ-022: RESP SHALL last exactly one cycle and then go to IDLE. req_ready SHALL return to 1 at the edge after RESP. Back-to-back throughput SHALL be one access per WAIT+2 cycles.
- REQ-023: RAM addressing:
  - Little-endian.
  - Word index = address[log2(DEPTH)+1:2].
  - Byte lane = address[1:0]. Halfword lane = address[1].
- REQ-024: Stores SHALL write only the addressed lanes, using write_data[7:0], [15:0] or [31:0]. The other bytes SHALL be unchanged. The write SHALL commit at the same edge that resp_valid rises.
- REQ-025: Loads SHALL select the addressed lane and extend it per the latched req_signed. read_data SHALL be valid while resp_valid=1.
- REQ-026: read_data SHALL hold its value until the next resp_valid. Stores SHALL return read_data=0.
- REQ-027: resp_valid SHALL never be asserted in IDLE or BUSY. error SHALL be 0 whenever resp_valid=0.
- REQ-028: RAM contents SHALL be uninitialised and SHALL NOT be affected by reset.

Reset
- REQ-029: While rst_n=0 at an edge, outputs SHALL take these values: FSM=IDLE, counter=0, resp_valid=0, error=0, read_data=0, req_ready=1 after that edge, stall=req_valid&&!req_ready.
- REQ-030: Reset SHALL take priority over every transition. If rst_n=0 is sampled at or before the commit edge, the in-flight store SHALL NOT be written and no resp_valid SHALL be produced.
- REQ-031: A request presented at an edge where rst_n=0 SHALL NOT be accepted.

Verification (WAIT=2, DEPTH=256)
- REQ-032: Store word 0x11223344 at 0x4, then load word 0x4 unsigned -> resp_valid 3 cycles after each acceptance, read_data=0x11223344, error=0.
- REQ-033: Store byte 0xAB at 0x6, then load word 0x4 -> 0x11AB3344. Load byte 0x6 signed -> 0xFFFFFFAB. Unsigned -> 0x000000AB.
- REQ-034: Load halfword 0x5 -> resp_valid 1 cycle after acceptance with error=1, read_data=0. Store word 0x400 -> error=1 and no RAM change.
- REQ-035: Hold req_valid=1 during BUSY -> stall=1 and req_ready=0. The second request is accepted only in the cycle after resp_valid.
- REQ-036: Assert rst_n=0 one cycle after a store to 0x8 is accepted -> no resp_valid, and a later load from 0x8 returns the prior contents.
- REQ-037: Rebuild with WAIT=0 and store then load word 0x0 -> resp_valid 1 cycle after acceptance, with correct data.
